// File: rtl/exc_commit_unit_pkg.sv
// Shared definitions for the MEM->WB exception commit stage: ExcCodes,
// raw exception flag indices and the commit FSM states.
package exc_commit_unit_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int unsigned NumExcFlags = 10;

  // Bit positions inside MEM_Exc; the order is also the priority order.
  typedef enum logic [3:0] {
    FlagIfAdel       = 4'd0,
    FlagIfTlbRefill  = 4'd1,
    FlagIfTlbInvalid = 4'd2,
    FlagRi           = 4'd3,
    FlagOv           = 4'd4,
    FlagSys          = 4'd5,
    FlagBreak        = 4'd6,
    FlagDAde         = 4'd7,
    FlagDTlbRefill   = 4'd8,
    FlagDTlbInvalid  = 4'd9
  } exc_flag_e;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFlush = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    BadNone = 2'd0,
    BadPc   = 2'd1,
    BadData = 2'd2
  } bad_src_e;

  function automatic logic [4:0] pick_code(input logic is_store, input logic [4:0] load_code,
                                           input logic [4:0] store_code);
    return is_store ? store_code : load_code;
  endfunction

endpackage

// File: rtl/exc_commit_unit_if.sv
// MEM/CP0-facing signal bundle of the exception commit stage.
interface exc_commit_unit_if;
  import exc_commit_unit_pkg::*;

  logic [5:0]             Interrupt;
  logic [5:0]             Int_Sync;
  logic                   MEM_Valid;
  logic                   MEM_Stall;
  logic [NumExcFlags-1:0] MEM_Exc;
  logic                   MEM_Exc_Mod;
  logic                   MEM_IsStore;
  logic                   MEM_IsERET;
  logic [31:0]            MEM_PC;
  logic                   MEM_IsInDelaySlot;
  logic [31:0]            MEM_ALUOut;
  logic                   CP0_IE;
  logic                   CP0_EXL;
  logic [7:0]             CP0_IM;
  logic [7:0]             CP0_IP;
  logic [31:0]            CP0_EPC;
  logic                   WB_ExcValid;
  logic [4:0]             WB_ExcCode;
  logic [31:0]            WB_PC;
  logic                   WB_IsInDelaySlot;
  logic [31:0]            WB_BadVAddr;
  logic                   WB_IsERET;
  logic                   Flush_All;
  logic                   Redirect_Valid;
  logic [31:0]            Redirect_PC;

  modport master (
    output Interrupt, MEM_Valid, MEM_Stall, MEM_Exc, MEM_Exc_Mod, MEM_IsStore, MEM_IsERET,
           MEM_PC, MEM_IsInDelaySlot, MEM_ALUOut, CP0_IE, CP0_EXL, CP0_IM, CP0_IP, CP0_EPC,
    input  Int_Sync, WB_ExcValid, WB_ExcCode, WB_PC, WB_IsInDelaySlot, WB_BadVAddr, WB_IsERET,
           Flush_All, Redirect_Valid, Redirect_PC
  );

  modport slave (
    input  Interrupt, MEM_Valid, MEM_Stall, MEM_Exc, MEM_Exc_Mod, MEM_IsStore, MEM_IsERET,
           MEM_PC, MEM_IsInDelaySlot, MEM_ALUOut, CP0_IE, CP0_EXL, CP0_IM, CP0_IP, CP0_EPC,
    output Int_Sync, WB_ExcValid, WB_ExcCode, WB_PC, WB_IsInDelaySlot, WB_BadVAddr, WB_IsERET,
           Flush_All, Redirect_Valid, Redirect_PC
  );

endinterface

// File: rtl/exc_commit_unit_int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines.
module exc_commit_unit_int_sync #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned Width      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] async_i,
  output logic [Width-1:0] sync_o
);

  logic [Width-1:0] sync_q [SyncStages];
  logic [Width-1:0] sync_d [SyncStages];

  always_comb begin
    sync_d[0] = async_i;
    for (int unsigned i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < SyncStages; i++) begin
      if (rst) begin
        sync_q[i] <= '0;
      end else begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign sync_o = sync_q[SyncStages-1];

endmodule

// File: rtl/exc_commit_unit.sv
// MEM->WB exception commit: interrupt acceptance, exception priority,
// registered WB exception fields, one-cycle flush and PC redirect.
module exc_commit_unit
  import exc_commit_unit_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
  parameter logic [31:0] REFILL_VECTOR = 32'hBFC0_0200,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input logic               clk,
  input logic               rst,
  exc_commit_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic        exc_valid_q, exc_valid_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] wb_pc_q, wb_pc_d;
  logic        wb_ds_q, wb_ds_d;
  logic [31:0] bad_vaddr_q, bad_vaddr_d;
  logic        wb_eret_q, wb_eret_d;
  logic        flush_q, flush_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        int_pend, accept, exc_hit, exc_refill;
  logic [4:0]  exc_code;
  bad_src_e    bad_src;
  logic [31:0] bad_addr;
  logic [5:0]  int_sync;

  exc_commit_unit_int_sync #(
    .SyncStages (SYNC_STAGES),
    .Width      (6)
  ) u_int_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.Interrupt),
    .sync_o  (int_sync)
  );

  assign int_pend = bus.CP0_IE & ~bus.CP0_EXL & (|(bus.CP0_IP & bus.CP0_IM));
  // The instruction sitting in MEM during FLUSH is killed, hence the state term.
  assign accept   = (state_q == StRun) & bus.MEM_Valid & ~bus.MEM_Stall;

  always_comb begin
    exc_hit    = 1'b1;
    exc_code   = EXC_INT;
    exc_refill = 1'b0;
    bad_src    = BadNone;
    if (int_pend) begin
      exc_code = EXC_INT;
    end else if (bus.MEM_Exc[FlagIfAdel]) begin
      exc_code = EXC_ADEL;
      bad_src  = BadPc;
    end else if (bus.MEM_Exc[FlagIfTlbRefill]) begin
      exc_code   = EXC_TLBL;
      bad_src    = BadPc;
      exc_refill = 1'b1;
    end else if (bus.MEM_Exc[FlagIfTlbInvalid]) begin
      exc_code = EXC_TLBL;
      bad_src  = BadPc;
    end else if (bus.MEM_Exc[FlagRi]) begin
      exc_code = EXC_RI;
    end else if (bus.MEM_Exc[FlagOv]) begin
      exc_code = EXC_OV;
    end else if (bus.MEM_Exc[FlagSys]) begin
      exc_code = EXC_SYS;
    end else if (bus.MEM_Exc[FlagBreak]) begin
      exc_code = EXC_BP;
    end else if (bus.MEM_Exc[FlagDAde]) begin
      exc_code = pick_code(bus.MEM_IsStore, EXC_ADEL, EXC_ADES);
      bad_src  = BadData;
    end else if (bus.MEM_Exc[FlagDTlbRefill]) begin
      exc_code   = pick_code(bus.MEM_IsStore, EXC_TLBL, EXC_TLBS);
      bad_src    = BadData;
      exc_refill = 1'b1;
    end else if (bus.MEM_Exc[FlagDTlbInvalid]) begin
      exc_code = pick_code(bus.MEM_IsStore, EXC_TLBL, EXC_TLBS);
      bad_src  = BadData;
    end else if (bus.MEM_Exc_Mod) begin
      exc_code = EXC_MOD;
      bad_src  = BadData;
    end else begin
      exc_hit = 1'b0;
    end
  end

  always_comb begin
    case (bad_src)
      BadPc:   bad_addr = bus.MEM_PC;
      BadData: bad_addr = bus.MEM_ALUOut;
      default: bad_addr = '0;
    endcase
  end

  // Anything not accepted (stall, bubble, FLUSH) loads an all-zero WB bubble.
  always_comb begin
    state_d       = StRun;
    exc_valid_d   = 1'b0;
    exc_code_d    = '0;
    wb_pc_d       = '0;
    wb_ds_d       = 1'b0;
    bad_vaddr_d   = '0;
    wb_eret_d     = 1'b0;
    flush_d       = 1'b0;
    redir_valid_d = 1'b0;
    redir_pc_d    = '0;
    if (accept) begin
      wb_pc_d     = bus.MEM_PC;
      wb_ds_d     = bus.MEM_IsInDelaySlot;
      bad_vaddr_d = bad_addr;
      if (exc_hit) begin
        exc_valid_d   = 1'b1;
        exc_code_d    = exc_code;
        flush_d       = 1'b1;
        redir_valid_d = 1'b1;
        redir_pc_d    = (exc_refill & ~bus.CP0_EXL) ? REFILL_VECTOR : EXC_VECTOR;
        state_d       = StFlush;
      end else if (bus.MEM_IsERET) begin
        wb_eret_d     = 1'b1;
        flush_d       = 1'b1;
        redir_valid_d = 1'b1;
        redir_pc_d    = bus.CP0_EPC;
        state_d       = StFlush;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      exc_valid_q   <= 1'b0;
      exc_code_q    <= '0;
      wb_pc_q       <= '0;
      wb_ds_q       <= 1'b0;
      bad_vaddr_q   <= '0;
      wb_eret_q     <= 1'b0;
      flush_q       <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      exc_valid_q   <= exc_valid_d;
      exc_code_q    <= exc_code_d;
      wb_pc_q       <= wb_pc_d;
      wb_ds_q       <= wb_ds_d;
      bad_vaddr_q   <= bad_vaddr_d;
      wb_eret_q     <= wb_eret_d;
      flush_q       <= flush_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
    end
  end

  assign bus.Int_Sync         = int_sync;
  assign bus.WB_ExcValid      = exc_valid_q;
  assign bus.WB_ExcCode       = exc_code_q;
  assign bus.WB_PC            = wb_pc_q;
  assign bus.WB_IsInDelaySlot = wb_ds_q;
  assign bus.WB_BadVAddr      = bad_vaddr_q;
  assign bus.WB_IsERET        = wb_eret_q;
  assign bus.Flush_All        = flush_q;
  assign bus.Redirect_Valid   = redir_valid_q;
  assign bus.Redirect_PC      = redir_pc_q;

endmodule

// File: tb/tb_exc_commit_unit.sv
// Self-checking bench for exc_commit_unit: vector table, directed multi-cycle
// sequences and randomized stimulus against a priority-table reference model.
module tb_exc_commit_unit;

  localparam logic [31:0] ExcVec    = 32'hBFC0_0380;
  localparam logic [31:0] RefillVec = 32'hBFC0_0200;

  typedef struct packed {
    logic        valid;
    logic        stall;
    logic [9:0]  exc;
    logic        mod;
    logic        st;
    logic        eret;
    logic        ds;
    logic        ie;
    logic        exl;
    logic [7:0]  im;
    logic [7:0]  ip;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] epc;
  } mem_in_t;

  typedef struct packed {
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bad;
    logic [31:0] wbpc;
    logic        ds;
    logic        eret;
    logic        flush;
    logic [31:0] rpc;
  } exp_t;

  typedef struct packed {
    mem_in_t stim;
    exp_t    want;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];

  // Priority order: index 0 = interrupt, 1..10 = MEM_Exc[0..9], 11 = TLBMod.
  int code_ld  [12] = '{0, 4, 2, 2, 10, 12, 8, 9, 4, 2, 2, 1};
  int code_st  [12] = '{0, 4, 2, 2, 10, 12, 8, 9, 5, 3, 3, 1};
  int src_kind [12] = '{0, 1, 1, 1, 0, 0, 0, 0, 2, 2, 2, 2};

  exc_commit_unit_if bus ();

  exc_commit_unit #(
    .EXC_VECTOR    (ExcVec),
    .REFILL_VECTOR (RefillVec),
    .SYNC_STAGES   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t ref_model(input mem_in_t i, input logic killed);
    exp_t        e;
    logic [11:0] pend;
    int          win;
    e = '0;
    if (killed || !i.valid || i.stall) return e;
    e.wbpc = i.pc;
    e.ds   = i.ds;
    pend   = {i.mod, i.exc, i.ie & ~i.exl & (|(i.ip & i.im))};
    win    = -1;
    for (int k = 11; k >= 0; k--) if (pend[k]) win = k;
    if (win >= 0) begin
      e.exc  = 1'b1;
      e.code = 5'(i.st ? code_st[win] : code_ld[win]);
      e.bad  = (src_kind[win] == 1) ? i.pc : (src_kind[win] == 2) ? i.alu : 32'h0;
      e.rpc  = ((win == 2 || win == 9) && !i.exl) ? RefillVec : ExcVec;
    end else if (i.eret) begin
      e.eret = 1'b1;
      e.rpc  = i.epc;
    end
    e.flush = e.exc | e.eret;
    return e;
  endfunction

  function automatic mem_in_t vin(input logic [9:0] exc, input logic mod, input logic st,
                                  input logic eret, input logic ds, input logic intp,
                                  input logic exl, input logic [31:0] pc,
                                  input logic [31:0] alu, input logic [31:0] epc);
    mem_in_t i;
    i       = '0;
    i.valid = 1'b1;
    i.exc   = exc;
    i.mod   = mod;
    i.st    = st;
    i.eret  = eret;
    i.ds    = ds;
    i.ie    = 1'b1;
    i.exl   = exl;
    i.im    = 8'h04;
    i.ip    = intp ? 8'h04 : 8'h00;
    i.pc    = pc;
    i.alu   = alu;
    i.epc   = epc;
    return i;
  endfunction

  function automatic exp_t vx(input logic exc, input logic [4:0] code, input logic [31:0] bad,
                              input logic eret, input logic [31:0] rpc);
    exp_t e;
    e       = '0;
    e.exc   = exc;
    e.code  = code;
    e.bad   = bad;
    e.eret  = eret;
    e.flush = exc | eret;
    e.rpc   = rpc;
    return e;
  endfunction

  task automatic add_vec(input mem_in_t i, input exp_t e);
    vec_t v;
    v.stim = i;
    v.want = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, " WB_ExcValid"},      32'(bus.WB_ExcValid),      32'(e.exc));
    chk({tag, " WB_ExcCode"},       32'(bus.WB_ExcCode),       32'(e.code));
    chk({tag, " WB_PC"},            bus.WB_PC,                 e.wbpc);
    chk({tag, " WB_IsInDelaySlot"}, 32'(bus.WB_IsInDelaySlot), 32'(e.ds));
    chk({tag, " WB_BadVAddr"},      bus.WB_BadVAddr,           e.bad);
    chk({tag, " WB_IsERET"},        32'(bus.WB_IsERET),        32'(e.eret));
    chk({tag, " Flush_All"},        32'(bus.Flush_All),        32'(e.flush));
    chk({tag, " Redirect_Valid"},   32'(bus.Redirect_Valid),   32'(e.flush));
    chk({tag, " Redirect_PC"},      bus.Redirect_PC,           e.rpc);
  endtask

  task automatic drive(input mem_in_t i);
    bus.MEM_Valid         = i.valid;
    bus.MEM_Stall         = i.stall;
    bus.MEM_Exc           = i.exc;
    bus.MEM_Exc_Mod       = i.mod;
    bus.MEM_IsStore       = i.st;
    bus.MEM_IsERET        = i.eret;
    bus.MEM_IsInDelaySlot = i.ds;
    bus.CP0_IE            = i.ie;
    bus.CP0_EXL           = i.exl;
    bus.CP0_IM            = i.im;
    bus.CP0_IP            = i.ip;
    bus.MEM_PC            = i.pc;
    bus.MEM_ALUOut        = i.alu;
    bus.CP0_EPC           = i.epc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_in_t idle;
    mem_in_t s;
    exp_t    e;
    exp_t    zero;
    logic    killed;

    idle = '0;
    zero = '0;
    rst  = 1'b1;
    bus.Interrupt = 6'b0;
    drive(idle);
    tick();
    tick();
    check_out("reset", zero);
    chk("reset Int_Sync", 32'(bus.Int_Sync), 32'h0);
    rst = 1'b0;

    // Interrupt through the synchroniser, then taken on the next valid instruction.
    bus.Interrupt = 6'b000100;
    tick();
    chk("sync after 1 cycle", 32'(bus.Int_Sync), 32'h0);
    tick();
    chk("sync after 2 cycles", 32'(bus.Int_Sync), 32'h04);
    s       = idle;
    s.valid = 1'b1;
    s.ie    = 1'b1;
    s.im    = 8'h10;
    s.ip    = {bus.Int_Sync, 2'b00};
    s.pc    = 32'hBFC0_1000;
    drive(s);
    tick();
    e      = vx(1'b1, 5'd0, 32'h0, 1'b0, ExcVec);
    e.wbpc = 32'hBFC0_1000;
    check_out("int commit", e);
    drive(idle);
    tick();
    check_out("int after flush", zero);
    bus.Interrupt = 6'b0;

    add_vec(vin(10'h000, 0, 0, 0, 0, 0, 0, 32'h0000_1000, 32'h55, 32'h8000_0100),
            vx(0, 5'd0, 32'h0, 0, 32'h0));
    add_vec(vin(10'h082, 0, 0, 0, 0, 0, 0, 32'h0040_0010, 32'h8000_0003, 32'h0),
            vx(1, 5'd2, 32'h0040_0010, 0, RefillVec));
    add_vec(vin(10'h082, 0, 0, 0, 0, 0, 1, 32'h0040_0010, 32'h8000_0003, 32'h0),
            vx(1, 5'd2, 32'h0040_0010, 0, ExcVec));
    add_vec(vin(10'h080, 0, 1, 0, 1, 0, 0, 32'h0040_0020, 32'h8000_0003, 32'h0),
            vx(1, 5'd5, 32'h8000_0003, 0, ExcVec));
    add_vec(vin(10'h080, 0, 0, 0, 0, 0, 0, 32'h0040_0024, 32'h8000_0007, 32'h0),
            vx(1, 5'd4, 32'h8000_0007, 0, ExcVec));
    add_vec(vin(10'h038, 0, 0, 0, 0, 0, 0, 32'h0040_0030, 32'h1234, 32'h0),
            vx(1, 5'd10, 32'h0, 0, ExcVec));
    add_vec(vin(10'h050, 0, 0, 0, 0, 0, 0, 32'h0040_0034, 32'h1234, 32'h0),
            vx(1, 5'd12, 32'h0, 0, ExcVec));
    add_vec(vin(10'h060, 0, 0, 0, 0, 0, 0, 32'h0040_0038, 32'h1234, 32'h0),
            vx(1, 5'd8, 32'h0, 0, ExcVec));
    add_vec(vin(10'h040, 0, 0, 0, 1, 0, 0, 32'h0040_003C, 32'h1234, 32'h0),
            vx(1, 5'd9, 32'h0, 0, ExcVec));
    add_vec(vin(10'h100, 0, 1, 0, 0, 0, 0, 32'h0040_0040, 32'h7FFF_F000, 32'h0),
            vx(1, 5'd3, 32'h7FFF_F000, 0, RefillVec));
    add_vec(vin(10'h200, 0, 0, 0, 0, 0, 0, 32'h0040_0044, 32'h7FFF_E000, 32'h0),
            vx(1, 5'd2, 32'h7FFF_E000, 0, ExcVec));
    add_vec(vin(10'h000, 1, 1, 0, 0, 0, 0, 32'h0040_0048, 32'h7FFF_D000, 32'h0),
            vx(1, 5'd1, 32'h7FFF_D000, 0, ExcVec));
    add_vec(vin(10'h001, 0, 0, 0, 0, 1, 0, 32'h0040_004C, 32'h1, 32'h0),
            vx(1, 5'd0, 32'h0, 0, ExcVec));
    add_vec(vin(10'h001, 0, 0, 0, 0, 1, 1, 32'h0040_0050, 32'h1, 32'h0),
            vx(1, 5'd4, 32'h0040_0050, 0, ExcVec));
    add_vec(vin(10'h000, 0, 0, 1, 0, 0, 0, 32'h0040_0054, 32'h1, 32'h8000_0100),
            vx(0, 5'd0, 32'h0, 1, 32'h8000_0100));
    add_vec(vin(10'h020, 0, 0, 1, 0, 0, 0, 32'h0040_0058, 32'h1, 32'h8000_0100),
            vx(1, 5'd8, 32'h0, 0, ExcVec));
    add_vec(vin(10'h004, 0, 0, 0, 0, 0, 0, 32'h0040_005C, 32'h1, 32'h0),
            vx(1, 5'd2, 32'h0040_005C, 0, ExcVec));
    add_vec(vin(10'h100, 0, 0, 0, 0, 0, 1, 32'h0040_0060, 32'h9000_0000, 32'h0),
            vx(1, 5'd2, 32'h9000_0000, 0, ExcVec));
    add_vec(vin(10'h300, 0, 0, 0, 0, 0, 0, 32'h0040_0064, 32'h9000_0004, 32'h0),
            vx(1, 5'd2, 32'h9000_0004, 0, RefillVec));

    foreach (vecs[k]) begin
      e      = vecs[k].want;
      e.wbpc = vecs[k].stim.pc;
      e.ds   = vecs[k].stim.ds;
      drive(vecs[k].stim);
      tick();
      check_out($sformatf("vec%0d", k), e);
      drive(idle);
      tick();
      chk($sformatf("vec%0d single pulse", k), 32'(bus.Flush_All), 32'h0);
    end

    // ERET, then a syscall presented during the FLUSH cycle must be killed.
    s       = idle;
    s.valid = 1'b1;
    s.eret  = 1'b1;
    s.pc    = 32'h0000_1234;
    s.epc   = 32'h8000_0100;
    drive(s);
    tick();
    e      = vx(1'b0, 5'd0, 32'h0, 1'b1, 32'h8000_0100);
    e.wbpc = 32'h0000_1234;
    check_out("eret", e);
    s       = idle;
    s.valid = 1'b1;
    s.exc   = 10'h020;
    s.pc    = 32'h0000_2000;
    drive(s);
    tick();
    check_out("eret killed syscall", zero);
    drive(idle);
    tick();
    check_out("eret after", zero);

    // Pending interrupt held off by a 3-cycle stall.
    s       = idle;
    s.valid = 1'b1;
    s.stall = 1'b1;
    s.ie    = 1'b1;
    s.im    = 8'h04;
    s.ip    = 8'h04;
    s.pc    = 32'h0000_3000;
    drive(s);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_out($sformatf("stall%0d", c), zero);
    end
    s.stall = 1'b0;
    drive(s);
    tick();
    e      = vx(1'b1, 5'd0, 32'h0, 1'b0, ExcVec);
    e.wbpc = 32'h0000_3000;
    check_out("stall release int", e);
    drive(idle);
    tick();

    // Reset landing on the FLUSH cycle.
    bus.Interrupt = 6'h3F;
    tick();
    tick();
    s       = idle;
    s.valid = 1'b1;
    s.exc   = 10'h008;
    s.pc    = 32'h0000_4000;
    drive(s);
    tick();
    e      = vx(1'b1, 5'd10, 32'h0, 1'b0, ExcVec);
    e.wbpc = 32'h0000_4000;
    check_out("pre-reset commit", e);
    rst = 1'b1;
    drive(idle);
    tick();
    check_out("reset in flush", zero);
    chk("reset in flush Int_Sync", 32'(bus.Int_Sync), 32'h0);
    rst = 1'b0;
    bus.Interrupt = 6'b0;
    tick();
    check_out("after reset", zero);
    s       = idle;
    s.valid = 1'b1;
    s.exc   = 10'h040;
    s.pc    = 32'h0000_5000;
    drive(s);
    tick();
    e      = vx(1'b1, 5'd9, 32'h0, 1'b0, ExcVec);
    e.wbpc = 32'h0000_5000;
    check_out("run after reset", e);
    drive(idle);
    tick();

    killed = 1'b0;
    for (int n = 0; n < 500; n++) begin
      s       = '0;
      s.valid = ($urandom_range(3) != 0);
      s.stall = ($urandom_range(3) == 0);
      for (int b = 0; b < 10; b++) s.exc[b] = ($urandom_range(11) == 0);
      s.mod   = ($urandom_range(11) == 0);
      s.st    = 1'($urandom_range(1));
      s.eret  = ($urandom_range(5) == 0);
      s.ds    = 1'($urandom_range(1));
      s.ie    = 1'($urandom_range(1));
      s.exl   = 1'($urandom_range(1));
      s.im    = 8'($urandom);
      s.ip    = ($urandom_range(1) == 0) ? 8'h00 : 8'($urandom);
      s.pc    = $urandom;
      s.alu   = $urandom;
      s.epc   = $urandom;
      e       = ref_model(s, killed);
      drive(s);
      tick();
      check_out($sformatf("rand%0d", n), e);
      killed = e.flush;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
